// File: rtl/rv32i_tb_pkg.sv
// Shared types and byte-enable helpers for the RV32I store monitor.
// Holds the FIFO entry layout and the legal-lane / lane-mask functions.
package rv32i_tb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_event_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // Only naturally aligned byte, halfword and word lane patterns are accepted.
  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] mask_wdata(input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/rv32i_event_fifo.sv
// Circular event FIFO, DEPTH entries, registered head (no write-through bypass).
// Push is refused when full unless a pop happens on the same edge.
module rv32i_event_fifo
  import rv32i_tb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  store_event_t               push_data,
  input  logic                       pop,
  output store_event_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);

  store_event_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    cnt;
  logic           pop_ok;
  logic           push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign level   = cnt;
  assign pop_ok  = pop & ~empty;
  // A pop on the same edge frees the slot the push is about to take.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rv32i_store_monitor.sv
// Snoops accepted data-memory stores in an address window and queues masked events.
// One-edge capture latency; consumer stalls via store_ready_i, overflow drops are sticky.
module rv32i_store_monitor
  import rv32i_tb_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_we_i,
  input  logic [31:0]            dmem_addr_i,
  input  logic [3:0]             dmem_be_i,
  input  logic [31:0]            dmem_wdata_i,
  input  logic                   store_ready_i,
  output logic                   store_valid_o,
  output logic [31:0]            store_addr_o,
  output logic [31:0]            store_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic                   illegal_be_o,
  output logic [31:0]            store_count_o
);

  logic [31:0]  aligned;
  logic [32:0]  lo_diff;
  logic [32:0]  hi_diff;
  logic         in_window;
  logic         capture;
  logic         push_req;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  store_event_t push_data;
  store_event_t head;

  assign aligned = word_align(dmem_addr_i);

  // Window check by borrow bit keeps the compare free of constant-fold warnings
  // when the window spans the full address space.
  assign lo_diff   = {1'b0, aligned} - {1'b0, ADDR_LO};
  assign hi_diff   = {1'b0, ADDR_HI} - {1'b0, aligned};
  assign in_window = ~lo_diff[32] & ~hi_diff[32];

  assign capture   = enable_i & dmem_req_i & dmem_gnt_i & dmem_we_i & in_window;
  assign push_req  = capture & be_legal(dmem_be_i);
  assign pop       = store_valid_o & store_ready_i;
  assign push      = push_req & (~full | pop);

  assign push_data.addr = aligned;
  assign push_data.data = mask_wdata(dmem_wdata_i, dmem_be_i);

  rv32i_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  // Storage is not reset, so the head is forced to zero whenever nothing is buffered.
  assign store_valid_o = ~empty;
  assign store_addr_o  = empty ? 32'h0 : head.addr;
  assign store_data_o  = empty ? 32'h0 : head.data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o    <= 1'b0;
      illegal_be_o  <= 1'b0;
      store_count_o <= '0;
    end else begin
      if (push_req & full & ~pop)               overflow_o   <= 1'b1;
      if (capture & ~be_legal(dmem_be_i))       illegal_be_o <= 1'b1;
      if (pop && (store_count_o != 32'hFFFF_FFFF)) store_count_o <= store_count_o + 32'd1;
    end
  end

endmodule
